// File: rtl/gpu_op_arbiter_if.sv
// Op type shared by the producers and the GPU op FIFO, plus the interface
// that bundles the producer-side ports and the FIFO write port of the
// arbiter.
package gpu_op_pkg;
  typedef logic [31:0] gpu_op_t;
endpackage

interface gpu_op_arbiter_if #(
  parameter int REQ_COUNT = 2
);
  import gpu_op_pkg::*;

  // Producer side: one lock, op, push strobe and back-pressure per requester
  logic    [REQ_COUNT-1:0] req_lock;
  gpu_op_t [REQ_COUNT-1:0] req_op;
  logic    [REQ_COUNT-1:0] req_wr_en;
  logic    [REQ_COUNT-1:0] req_full;

  // GPU op FIFO write port
  gpu_op_t op;
  logic    op_wr_en;
  logic    op_full;

  // Arbiter view
  modport slave (
    input  req_lock, req_op, req_wr_en, op_full,
    output req_full, op, op_wr_en
  );

  // Environment view: producers plus the FIFO
  modport master (
    output req_lock, req_op, req_wr_en, op_full,
    input  req_full, op, op_wr_en
  );
endinterface

// File: rtl/gpu_op_arbiter.sv
// Round-robin arbiter sharing the GPU op FIFO write port between several
// producers. A producer holds the port for as long as its lock is high; its
// ops pass through a one-entry output register so that a full FIFO never
// forces the arbiter to drop or reorder an op.
module gpu_op_arbiter
  import gpu_op_pkg::*;
#(
  parameter int REQ_COUNT = 2,
  parameter int IDX_WIDTH = (REQ_COUNT > 1) ? $clog2(REQ_COUNT) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ce,
  gpu_op_arbiter_if.slave      bus,
  output logic [IDX_WIDTH-1:0] owner,
  output logic                 busy,
  output logic                 idle
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [IDX_WIDTH-1:0] owner_q, owner_d;
  logic [IDX_WIDTH-1:0] last_q, last_d;
  logic                 valid_q, valid_d;
  gpu_op_t              op_q, op_d;

  logic                 pick_valid;
  logic [IDX_WIDTH-1:0] pick_idx;
  logic                 accept;

  // Round-robin pick: first locked requester after the previous owner.
  // Walking the offsets downwards lets the nearest candidate win last.
  always_comb begin
    int                   cand;
    logic [IDX_WIDTH-1:0] cand_idx;
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    cand_idx   = '0;
    for (int k = REQ_COUNT; k >= 1; k--) begin
      cand     = (int'(last_q) + k) % REQ_COUNT;
      cand_idx = IDX_WIDTH'(cand);
      if (bus.req_lock[cand_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  // Only the grant holder may push, and only while the output register can
  // take a new op this cycle.
  for (genvar gi = 0; gi < REQ_COUNT; gi++) begin : g_full
    assign bus.req_full[gi] = !(state_q == ST_GRANT && owner_q == IDX_WIDTH'(gi))
                              || (valid_q && bus.op_full) || !ce;
  end

  assign accept       = bus.req_wr_en[owner_q] && !bus.req_full[owner_q];
  assign bus.op_wr_en = valid_q && !bus.op_full && ce;
  assign bus.op       = op_q;
  assign owner        = owner_q;
  assign busy         = (state_q == ST_GRANT);
  assign idle         = (state_q == ST_IDLE) && !valid_q;

  // Next-state logic for the output register and the grant FSM
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    valid_d = valid_q;
    op_d    = op_q;

    if (accept) begin
      op_d    = bus.req_op[owner_q];
      valid_d = 1'b1;
    end else if (bus.op_wr_en) begin
      valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          owner_d = pick_idx;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        // An op pushed on the release cycle is still accepted above.
        if (!bus.req_lock[owner_q]) begin
          last_d  = owner_q;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Hold off the next owner until the last op has left the register.
        if (!valid_q || bus.op_wr_en) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; everything freezes while ce is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      last_q  <= IDX_WIDTH'(REQ_COUNT - 1);
      valid_q <= 1'b0;
      op_q    <= '0;
    end else if (ce) begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      op_q    <= op_d;
    end
  end

endmodule

// File: tb/tb_gpu_op_arbiter.sv
// Bench for gpu_op_arbiter: directed scenarios plus randomized traffic, all
// checked every cycle against a queue-based model of grant ownership and the
// single-entry output buffer.
module tb_gpu_op_arbiter;
  import gpu_op_pkg::*;

  localparam int N = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ce;
  logic [0:0] owner;
  logic       busy;
  logic       idle;

  gpu_op_arbiter_if #(.REQ_COUNT(N)) bus ();

  gpu_op_arbiter #(.REQ_COUNT(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ce    (ce),
    .bus   (bus),
    .owner (owner),
    .busy  (busy),
    .idle  (idle)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;
  int wr_cnt = 0;
  int wr5    = 0;
  bit saw9   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: who holds the port (-1 = nobody), whether that holder has
  // released and is draining, and the ops waiting for the FIFO.
  int      m_holder = -1;
  int      m_last   = N - 1;
  bit      m_drain  = 0;
  gpu_op_t m_buf[$];
  gpu_op_t m_op     = '0;

  // Compare process: check outputs against the model, then advance it
  always @(negedge clk) begin
    bit         granted, found, acc;
    bit         e_wr, e_busy, e_idle;
    logic [N-1:0] e_full;
    int         c;
    if (!rst_n) begin
      m_holder = -1; m_last = N - 1; m_drain = 0; m_buf.delete(); m_op = '0;
    end
    granted = (m_holder >= 0) && !m_drain;
    e_wr    = (m_buf.size() > 0) && !bus.op_full && ce;
    for (int i = 0; i < N; i++)
      e_full[i] = !(granted && m_holder == i) || (m_buf.size() > 0 && bus.op_full) || !ce;
    e_busy = granted;
    e_idle = (m_holder < 0) && (m_buf.size() == 0);

    chk("op_wr_en", 32'(bus.op_wr_en), 32'(e_wr));
    chk("req_full", 32'(bus.req_full), 32'(e_full));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("idle", 32'(idle), 32'(e_idle));
    chk("op", bus.op, e_wr ? m_buf[0] : m_op);
    if (e_busy) chk("owner", 32'(owner), 32'(m_holder));

    if (rst_n && bus.op_wr_en) begin
      wr_cnt++;
      if (bus.op == 32'd5) wr5++;
      if (bus.op == 32'd9) saw9 = 1;
    end

    if (rst_n && ce) begin
      acc = granted && bus.req_wr_en[m_holder] && !e_full[m_holder];
      if (e_wr) void'(m_buf.pop_front());
      if (acc) begin
        m_buf.push_back(bus.req_op[m_holder]);
        m_op = bus.req_op[m_holder];
      end
      if (m_holder < 0) begin
        found = 0;
        for (int k = 1; k <= N; k++) begin
          c = (m_last + k) % N;
          if (!found && bus.req_lock[c]) begin
            m_holder = c;
            found = 1;
          end
        end
      end else if (!m_drain) begin
        if (!bus.req_lock[m_holder]) begin
          m_last  = m_holder;
          m_drain = 1;
        end
      end else if (m_buf.size() == 0) begin
        m_holder = -1;
        m_drain  = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input int o);
    for (int t = 0; t < 20; t++) begin
      if (busy && owner == 1'(o)) break;
      step();
    end
    chk("grant", {30'b0, busy, owner}, {30'b0, 1'b1, 1'(o)});
  endtask

  task automatic release_all();
    bus.req_lock = '0;
    bus.req_wr_en = '0;
    repeat (4) step();
  endtask

  initial begin
    int base;
    rst_n = 1'b1;
    ce = 1'b1;
    bus.req_lock = '0;
    bus.req_wr_en = '0;
    bus.req_op = '0;
    bus.op_full = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("rst_op_wr_en", 32'(bus.op_wr_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_req_full", 32'(bus.req_full), 32'b11);
    repeat (2) step();
    rst_n = 1'b1;
    step();

    // Single owner streams three ops back to back
    bus.req_lock = 2'b01;
    chk("no_grant_on_choice", 32'(busy), 32'd0);
    step();
    chk("grant0_busy", 32'(busy), 32'd1);
    chk("grant0_owner", 32'(owner), 32'd0);
    for (int x = 1; x <= 3; x++) begin
      bus.req_op[0] = 32'(x);
      bus.req_wr_en[0] = 1'b1;
      step();
      chk("stream_wr", 32'(bus.op_wr_en), 32'd1);
      chk("stream_op", bus.op, 32'(x));
    end
    bus.req_wr_en = '0;
    step();
    chk("stream_done", 32'(bus.op_wr_en), 32'd0);
    release_all();
    chk("idle_after_stream", 32'(idle), 32'd1);

    // FIFO full holds the buffered op without duplicating it
    bus.req_lock = 2'b01;
    wait_grant(0);
    bus.req_op[0] = 32'd5;
    bus.req_wr_en[0] = 1'b1;
    bus.op_full = 1'b1;
    step();
    bus.req_wr_en = '0;
    repeat (4) begin
      chk("full_no_wr", 32'(bus.op_wr_en), 32'd0);
      chk("full_hold_op", bus.op, 32'd5);
      chk("full_req_full0", 32'(bus.req_full[0]), 32'd1);
      step();
    end
    base = wr5;
    bus.op_full = 1'b0;
    #1;
    chk("full_release_wr", 32'(bus.op_wr_en), 32'd1);
    repeat (3) step();
    chk("full_single_write", 32'(wr5 - base), 32'd1);
    release_all();

    // Non-owner pushes are dropped
    bus.req_lock = 2'b01;
    wait_grant(0);
    bus.req_op[1] = 32'd9;
    bus.req_wr_en[1] = 1'b1;
    repeat (4) begin
      chk("nonowner_full", 32'(bus.req_full[1]), 32'd1);
      step();
    end
    release_all();
    chk("nonowner_dropped", 32'(saw9), 32'd0);

    // Reset mid-grant with an op buffered
    bus.req_lock = 2'b01;
    wait_grant(0);
    bus.req_op[0] = 32'h77;
    bus.req_wr_en[0] = 1'b1;
    step();
    bus.req_wr_en = '0;
    bus.op_full = 1'b1;
    step();
    base = wr_cnt;
    rst_n = 1'b0;
    #1;
    chk("midrst_wr", 32'(bus.op_wr_en), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_idle", 32'(idle), 32'd1);
    bus.op_full = 1'b0;
    step();
    rst_n = 1'b1;
    bus.req_lock = 2'b11;
    wait_grant(0);
    chk("midrst_discard", 32'(wr_cnt - base), 32'd0);

    // Both lock continuously; each releases after two ops
    for (int r = 0; r < 4; r++) begin
      int o;
      o = r % 2;
      wait_grant(o);
      bus.req_op[o] = 32'h200 + 32'(2 * r);
      bus.req_wr_en[o] = 1'b1;
      step();
      bus.req_op[o] = 32'h201 + 32'(2 * r);
      bus.req_lock[o] = 1'b0;
      step();
      bus.req_wr_en[o] = 1'b0;
      bus.req_lock[o] = 1'b1;
    end
    release_all();

    // Clock enable low mid-stream
    bus.req_lock = 2'b01;
    wait_grant(0);
    base = wr_cnt;
    for (int i = 0; i < 8; i++) begin
      bus.req_op[0] = 32'h300 + 32'(i);
      bus.req_wr_en[0] = 1'b1;
      if (i == 3) begin
        ce = 1'b0;
        repeat (3) begin
          #1;
          chk("ce_low_no_wr", 32'(bus.op_wr_en), 32'd0);
          chk("ce_low_busy", 32'(busy), 32'd1);
          step();
        end
        ce = 1'b1;
      end
      step();
    end
    release_all();
    chk("ce_stream_count", 32'(wr_cnt - base), 32'd8);

    // Randomized traffic
    for (int t = 0; t < 1500; t++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(7) == 0) bus.req_lock[i] = ~bus.req_lock[i];
        bus.req_wr_en[i] = 1'($urandom_range(1));
        bus.req_op[i] = {8'hA0, 24'($urandom)};
      end
      bus.op_full = ($urandom_range(3) == 0);
      ce = ($urandom_range(9) != 0);
      step();
    end
    ce = 1'b1;
    bus.op_full = 1'b0;
    release_all();
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
